// File: rtl/ram_serial_tx_pkg.sv
// Shared types and constants for the RAM-to-serial transmitter.
// Optional feature macro: RAM_SERIAL_TX_PARITY_EN (even-parity bit after the data bits).
package ram_serial_tx_pkg;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic LINE_IDLE       = 1'b1;
    localparam logic START_BIT       = 1'b0;
    localparam int   BIT_CNT_W       = $clog2(FRAME_DATA_BITS) + 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
`ifdef RAM_SERIAL_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        DONE
    } state_e;

    // Per-clk instruction from the FSM to the shifter.
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_START,
        CMD_DATA,
`ifdef RAM_SERIAL_TX_PARITY_EN
        CMD_PARITY,
`endif
        CMD_STOP
    } shift_cmd_e;

endpackage

// File: rtl/ram_serial_tx_if.sv
// Transfer request, RAM read port and serial line of the transmitter.
// The slave modport is the transmitter's view; master is the driving environment.
interface ram_serial_tx_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              baud_tick;
    logic              send;
    logic [ADDR_W-1:0] word_count;
    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] addr;
    logic              serialOut;
    logic              busy;
    logic              done;

    modport master (
        output baud_tick, send, word_count, ram_data,
        input  addr, serialOut, busy, done
    );

    modport slave (
        input  baud_tick, send, word_count, ram_data,
        output addr, serialOut, busy, done
    );
endinterface

// File: rtl/ram_serial_tx_shifter.sv
// Byte shift register, data-bit counter and registered serial line driver.
// With RAM_SERIAL_TX_PARITY_EN the even parity of the loaded byte is kept for the parity bit.
module ram_serial_tx_shifter
    import ram_serial_tx_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  shift_cmd_e                 cmd,
    input  logic [FRAME_DATA_BITS-1:0] load_data,
    output logic                       line,
    output logic                       last_bit
);

    logic [FRAME_DATA_BITS-1:0] shift_q;
    logic [BIT_CNT_W-1:0]       cnt_q;
    logic                       line_q;
`ifdef RAM_SERIAL_TX_PARITY_EN
    logic                       parity_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            line_q   <= LINE_IDLE;
`ifdef RAM_SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (cmd)
                CMD_LOAD: begin
                    shift_q  <= load_data;
                    cnt_q    <= '0;
`ifdef RAM_SERIAL_TX_PARITY_EN
                    parity_q <= ^load_data;
`endif
                end
                CMD_START: line_q <= START_BIT;
                CMD_DATA: begin
                    line_q  <= shift_q[0];
                    shift_q <= {1'b0, shift_q[FRAME_DATA_BITS-1:1]};
                    cnt_q   <= cnt_q + BIT_CNT_W'(1);
                end
`ifdef RAM_SERIAL_TX_PARITY_EN
                CMD_PARITY: line_q <= parity_q;
`endif
                CMD_STOP: line_q <= LINE_IDLE;
                default: ;
            endcase
        end
    end

    assign line     = line_q;
    assign last_bit = (cnt_q == BIT_CNT_W'(FRAME_DATA_BITS - 1));

endmodule

// File: rtl/ram_serial_tx.sv
// Reads word_count words from RAM and sends each low byte as a UART frame (8N1, or 8E1
// when RAM_SERIAL_TX_PARITY_EN is defined). Holds the FSM, addressing and handshake.
module ram_serial_tx
    import ram_serial_tx_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input logic           clk,
    input logic           reset,
    ram_serial_tx_if.slave bus
);

    state_e            state_q, state_d;
    shift_cmd_e        cmd;
    logic [ADDR_W-1:0] addr_q, count_q, addr_plus1;
    logic              busy_q, done_q, stop_sent_q, stop_sent_d;
    logic              accept, advance, last_bit, line;

    assign addr_plus1 = addr_q + ADDR_W'(1);

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        cmd         = CMD_NONE;
        accept      = 1'b0;
        advance     = 1'b0;
        stop_sent_d = stop_sent_q;
        case (state_q)
            IDLE: if (bus.send) begin
                accept  = 1'b1;
                state_d = (bus.word_count == '0) ? DONE : FETCH;
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                cmd     = CMD_LOAD;
                state_d = START;
            end
            START: if (bus.baud_tick) begin
                cmd     = CMD_START;
                state_d = DATA;
            end
            DATA: if (bus.baud_tick) begin
                cmd = CMD_DATA;
`ifdef RAM_SERIAL_TX_PARITY_EN
                if (last_bit) state_d = PARITY;
`else
                if (last_bit) state_d = STOP;
`endif
            end
`ifdef RAM_SERIAL_TX_PARITY_EN
            PARITY: if (bus.baud_tick) begin
                cmd     = CMD_PARITY;
                state_d = STOP;
            end
`endif
            // First tick puts the stop bit on the line, the second ends it.
            STOP: if (bus.baud_tick) begin
                if (!stop_sent_q) begin
                    cmd         = CMD_STOP;
                    stop_sent_d = 1'b1;
                end else begin
                    stop_sent_d = 1'b0;
                    advance     = 1'b1;
                    state_d     = (addr_plus1 == count_q) ? DONE : FETCH;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_sent_q <= stop_sent_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
            if (accept) begin
                count_q <= bus.word_count;
                addr_q  <= '0;
            end else if (advance) begin
                addr_q  <= addr_plus1;
            end
        end
    end

    ram_serial_tx_shifter u_shifter (
        .clk      (clk),
        .reset    (reset),
        .cmd      (cmd),
        .load_data(bus.ram_data[FRAME_DATA_BITS-1:0]),
        .line     (line),
        .last_bit (last_bit)
    );

    if (DATA_W > FRAME_DATA_BITS) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^bus.ram_data[DATA_W-1:FRAME_DATA_BITS];
    end

    assign bus.addr      = addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.serialOut = line;

endmodule

// File: tb/tb_ram_serial_tx.sv
// Directed bench for ram_serial_tx: table of transfers decoded off serialOut, plus
// hand-written sequences for empty transfer, ignored re-send, mid-frame reset and full count.
module tb_ram_serial_tx;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
`ifdef RAM_SERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_serial_tx_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    ram_serial_tx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    // RAM with one clk read latency.
    logic [DATA_W-1:0] ram [256];
    logic [DATA_W-1:0] ram_q;
    always @(posedge clk) ram_q <= ram[bus.addr];
    assign bus.ram_data = ram_q;

    int tick_period = 1;
    int tick_div    = 0;
    always @(negedge clk) begin
        tick_div      = (tick_div + 1 >= tick_period) ? 0 : tick_div + 1;
        bus.baud_tick = (tick_div == 0);
    end

    int done_cnt = 0;
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    typedef struct packed {
        int              period;
        logic [7:0]      word_count;
        logic [2:0][15:0] words;
        logic [2:0][7:0] exp_bytes;
        logic [2:0]      exp_par;
    } vec_t;

    localparam int N_VEC = 5;
    vec_t vecs [N_VEC];

    // Waits (bounded) for a start bit, then samples the whole frame one value per clk.
    task automatic recv_frame(input int period, output logic [7:0] data, output logic par,
                              output logic [ADDR_W-1:0] at_addr, output bit framing_ok, output bit got);
        logic [FRAME_BITS-1:0] bits;
        int waited;
        bits = '0; waited = 0; got = 0; framing_ok = 0; data = '0; par = 1'b0; at_addr = '0;
        while (bus.serialOut !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (bus.serialOut !== 1'b0) return;
        got = 1; framing_ok = 1; at_addr = bus.addr;
        for (int t = 0; t < FRAME_BITS * period; t++) begin
            if (t % period == 0) bits[t / period] = bus.serialOut;
            else if (bus.serialOut !== bits[t / period]) framing_ok = 0;
            @(negedge clk);
        end
        if (bits[FRAME_BITS-1] !== 1'b1) framing_ok = 0;
        data = bits[8:1];
        par  = bits[9];
    endtask

    task automatic pulse_send(input logic [7:0] count);
        bus.word_count = count;
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0] d;
        logic p;
        logic [ADDR_W-1:0] a;
        bit ok, got;
        int base;
        tick_period = v.period;
        for (int i = 0; i < 3; i++) ram[i] = v.words[i];
        base = done_cnt;
        pulse_send(v.word_count);
        check($sformatf("v%0d busy_after_send", idx), 32'(bus.busy), 32'd1);
        for (int f = 0; f < int'(v.word_count); f++) begin
            recv_frame(v.period, d, p, a, ok, got);
            check($sformatf("v%0d f%0d start_seen", idx, f), 32'(got), 32'd1);
            if (!got) return;
            check($sformatf("v%0d f%0d data", idx, f), 32'(d), 32'(v.exp_bytes[f]));
            check($sformatf("v%0d f%0d addr", idx, f), 32'(a), 32'(f));
            check($sformatf("v%0d f%0d framing", idx, f), 32'(ok), 32'd1);
`ifdef RAM_SERIAL_TX_PARITY_EN
            check($sformatf("v%0d f%0d parity", idx, f), 32'(p), 32'(v.exp_par[f]));
`endif
        end
        check($sformatf("v%0d done_after_last_stop", idx), 32'(bus.done), 32'd1);
        @(negedge clk);
        check($sformatf("v%0d busy_dropped", idx), 32'(bus.busy), 32'd0);
        check($sformatf("v%0d done_count", idx), 32'(done_cnt - base), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic p;
        logic [ADDR_W-1:0] a;
        bit ok, got;
        int base, lows, found;
        logic [7:0] rb [3];
        logic [ADDR_W-1:0] ra [3];
        int data_err, addr_err, frames;

        vecs[0] = '{period: 1, word_count: 8'd3, words: {16'hFF01, 16'h00A3, 16'h0055},
                    exp_bytes: {8'h01, 8'hA3, 8'h55}, exp_par: 3'b100};
        vecs[1] = '{period: 4, word_count: 8'd3, words: {16'hFF01, 16'h00A3, 16'h0055},
                    exp_bytes: {8'h01, 8'hA3, 8'h55}, exp_par: 3'b100};
        vecs[2] = '{period: 1, word_count: 8'd2, words: {16'h0000, 16'hAB03, 16'h1207},
                    exp_bytes: {8'h00, 8'h03, 8'h07}, exp_par: 3'b001};
        vecs[3] = '{period: 3, word_count: 8'd1, words: {16'h0000, 16'h0000, 16'h00FF},
                    exp_bytes: {8'h00, 8'h00, 8'hFF}, exp_par: 3'b000};
        vecs[4] = '{period: 2, word_count: 8'd1, words: {16'h0000, 16'h0000, 16'h3C80},
                    exp_bytes: {8'h00, 8'h00, 8'h80}, exp_par: 3'b001};

        for (int i = 0; i < 256; i++) ram[i] = '0;
        bus.send = 1'b0;
        bus.word_count = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset serialOut", 32'(bus.serialOut), 32'd1);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset addr", 32'(bus.addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < N_VEC; i++) run_vec(i, vecs[i]);

        // Empty transfer: busy and done for exactly one clk, no start bit.
        tick_period = 1;
        base = done_cnt;
        pulse_send(8'd0);
        check("wc0 busy", 32'(bus.busy), 32'd1);
        check("wc0 done", 32'(bus.done), 32'd1);
        lows = 0;
        @(negedge clk);
        check("wc0 busy_off", 32'(bus.busy), 32'd0);
        check("wc0 done_off", 32'(bus.done), 32'd0);
        repeat (20) begin
            if (bus.serialOut !== 1'b1) lows++;
            @(negedge clk);
        end
        check("wc0 no_start_bit", 32'(lows), 32'd0);
        check("wc0 done_count", 32'(done_cnt - base), 32'd1);

        // Re-send (with a different count) while busy must be ignored.
        tick_period = 2;
        ram[0] = 16'h0011; ram[1] = 16'h0022; ram[2] = 16'h0033;
        base = done_cnt;
        pulse_send(8'd3);
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    recv_frame(2, rb[f], p, ra[f], ok, got);
                    if (!got || !ok) rb[f] = 8'hEE;
                end
            end
            begin
                repeat (30) @(negedge clk);
                pulse_send(8'd1);
            end
        join
        check("resend bytes", 32'({rb[2], rb[1], rb[0]}), 32'h00332211);
        check("resend addrs", 32'({ra[2], ra[1], ra[0]}), 32'h00020100);
        check("resend done_at_end", 32'(bus.done), 32'd1);
        lows = 0;
        repeat (30) begin
            if (bus.serialOut !== 1'b1) lows++;
            @(negedge clk);
        end
        check("resend no_4th_frame", 32'(lows), 32'd0);
        check("resend done_count", 32'(done_cnt - base), 32'd1);

        // Reset during data bit 4 of 0x0F, reset beating send, then a clean restart.
        tick_period = 1;
        ram[0] = 16'h000F;
        pulse_send(8'd1);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (bus.serialOut === 1'b0) found = 1;
            else @(negedge clk);
        end
        check("rst start_seen", 32'(found), 32'd1);
        repeat (5) @(negedge clk);
        check("rst bit4_of_0F", 32'(bus.serialOut), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst serialOut", 32'(bus.serialOut), 32'd1);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst addr", 32'(bus.addr), 32'd0);
        bus.send = 1'b1;
        @(negedge clk);
        check("rst overrides send", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        bus.send = 1'b0;
        base = done_cnt;
        lows = 0;
        repeat (30) begin
            if (bus.serialOut !== 1'b1) lows++;
            @(negedge clk);
        end
        check("rst line_idle", 32'(lows), 32'd0);
        check("rst no_done", 32'(done_cnt - base), 32'd0);
        pulse_send(8'd1);
        recv_frame(1, d, p, a, ok, got);
        check("rst restart data", 32'(got ? d : 8'hEE), 32'h0F);
        check("rst restart addr", 32'(a), 32'd0);
        check("rst restart done", 32'(bus.done), 32'd1);
        @(negedge clk);

        // Maximum count: addresses 0..254, no wrap back to 0.
        for (int i = 0; i < 256; i++) ram[i] = {8'hC3, 8'(i)};
        base = done_cnt;
        data_err = 0; addr_err = 0; frames = 0;
        pulse_send(8'd255);
        for (int f = 0; f < 255; f++) begin
            recv_frame(1, d, p, a, ok, got);
            if (!got) break;
            frames++;
            if (!ok || d !== 8'(f)) data_err++;
            if (a !== 8'(f)) addr_err++;
        end
        check("max frames", 32'(frames), 32'd255);
        check("max data_errors", 32'(data_err), 32'd0);
        check("max addr_errors", 32'(addr_err), 32'd0);
        check("max done_at_end", 32'(bus.done), 32'd1);
        repeat (20) @(negedge clk);
        check("max done_count", 32'(done_cnt - base), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
